prefetch_stage: RTL and testbench
=================================

Name: prefetch_stage

Overview:
- Pre-fetch (PC-generation) stage that sits directly upstream of the fetch stage.
- Holds the fetch PC and issues two-instruction read requests to the ICache (words at addr and addr+4).
- On each ICache address acceptance, pushes a pair of PC/exception descriptors into the fetch stage's queue.
- Handles flush and backend branch redirects, and detects instruction-address errors.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded at reset.
- PC_STEP, 8, sequential advance per accepted request (two instructions).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush (exception/eret); highest priority.
- flush_pc  input  32  restart PC on flush.
- br_redirect  input  1  backend branch-mispredict redirect.
- br_target  input  32  redirect PC.
- fs_allowin  input  1  fetch queue has room for a pair.
- pfs_to_valid  output  1  pair accepted this cycle; fetch stage enqueues it.
- prefetch_to_fetch_bus1  output  prefetch_to_fetch_bus_t  slot 0 {valid, pc, exception}.
- prefetch_to_fetch_bus2  output  prefetch_to_fetch_bus_t  slot 1 {valid, pc+4, exception}.
- icache_req  output  1  read request.
- icache_addr  output  32  request address, word-aligned.
- icache_addr_ok  input  1  request accepted this cycle.
- bpu_pred_taken  input  1  (PFS_BPU_EN only) predicted taken for the current pair.
- bpu_pred_slot  input  1  (PFS_BPU_EN only) slot holding the branch: 0 or 1.
- bpu_pred_target  input  32  (PFS_BPU_EN only) predicted target.

Behaviour:
- Reset (async, active-high):
  - state=BOOT, pc=RESET_PC.
  - icache_req=0, pfs_to_valid=0, both bus valid=0, all bus fields 0.
- States:
  - BOOT: one idle cycle, then RUN.
  - RUN: normal issue.
  - HALT: after an address error is issued; no further requests.
- icache_req = (state==RUN) && fs_allowin && !flush && !br_redirect.
- icache_addr = {pc[31:2],2'b00}.
- pfs_to_valid = icache_req && icache_addr_ok. This is combinational, same cycle. The fetch stage's data_ok ordering relies on exactly one ICache request per enqueued pair.
- Bus contents while pfs_to_valid:
  - bus1 = {1, pc, exc}.
  - bus2 = {1, pc+4, exc}.
  - exc.adel = (pc[1:0]!=0); exc.badvaddr = pc.
  - Both slots carry the same exception.
- Next-PC priority, evaluated every clock edge:
  1. flush: pc<=flush_pc, state<=RUN (also exits HALT); any pending predicted target is cleared.
  2. br_redirect: pc<=br_target, state<=RUN; pending target cleared.
  3. pfs_to_valid with adel: state<=HALT, pc unchanged.
  4. pfs_to_valid: pc<=pc+PC_STEP, using 32-bit wrap-around.
  5. Otherwise: hold.
- A flush or redirect cycle issues no request. A request held off by !fs_allowin or !icache_addr_ok retries the same pc every cycle.
- flush and br_redirect together: flush wins.
- Reset asserted mid-request: everything drops immediately (async). The fetch stage is reset alongside, so no bookkeeping carries over.

Optional Feature:
- PFS_BPU_EN defined:
  - On pfs_to_valid with bpu_pred_taken and no adel:
    - slot 0 (delay slot is slot 1): pc<=bpu_pred_target.
    - slot 1 (delay slot is the next pair): pc<=pc+8, then latch pend_valid=1, pend_target=bpu_pred_target.
  - On the next pfs_to_valid with pend_valid=1: pc<=pend_target, pend_valid<=0, and the BPU inputs are ignored that cycle.
  - flush, br_redirect and reset clear pend_valid.
- PFS_BPU_EN undefined:
  - BPU ports are ignored (tie-off permitted).
  - No pend registers exist; next PC is purely sequential.

Test Plan:
- Reset release, fs_allowin=1, addr_ok=1 -> BOOT one cycle; then requests at BFC00000, BFC00008, BFC00010 on consecutive cycles; bus2.pc = BFC00004, BFC0000C, BFC00014.
- addr_ok=0 for 3 cycles at pc=BFC00010 -> icache_addr held at BFC00010, pfs_to_valid=0; accepted on cycle 4, next pc BFC00018.
- flush=1, flush_pc=BFC00380, same cycle as br_redirect=1, br_target=80001000 -> no request that cycle; next request addr BFC00380.
- br_redirect, br_target=80000102 -> request addr 80000100, bus1.exc.adel=1, badvaddr=80000102; then HALT with no requests until flush; flush_pc=BFC00380 resumes.
- PFS_BPU_EN, pc=80000000, pred_taken slot 1, target 80002000 -> next requests 80000008 then 80002000; slot 0 variant -> next request 80002000.
- PC wrap: pc=FFFFFFF8 accepted -> next pc 00000000, no exception.

Source files
------------

// File: rtl/prefetch_stage.sv
// prefetch_stage: PC-generation stage directly upstream of fetch.
//   Holds the fetch PC and issues one two-instruction ICache read per
//   pair (words at pc and pc+4). Each time the ICache accepts the address,
//   a pair of PC/exception descriptors is handed to the fetch queue in the
//   same cycle. Flush has priority over branch redirect, and both take
//   priority over sequential advance. A misaligned PC is issued once,
//   flagged as an address error, and the stage then halts until the next
//   flush or redirect.
//
// Optional feature macro: PFS_BPU_EN (branch-predictor driven next PC).
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   flush, flush_pc          pipeline flush and restart PC (highest priority)
//   br_redirect, br_target   backend mispredict redirect
//   fs_allowin               fetch queue has room for a pair
//   pfs_to_valid             pair accepted this cycle (combinational)
//   prefetch_to_fetch_bus1/2 slot descriptors, 66 bits each:
//                              [65] valid, [64:33] pc, [32] adel, [31:0] badvaddr
//   icache_req, icache_addr  read request and word-aligned address
//   icache_addr_ok           request accepted this cycle
//   bpu_pred_*               predictor inputs (used only with PFS_BPU_EN)
module prefetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        fs_allowin,
  output logic        pfs_to_valid,
  output logic [65:0] prefetch_to_fetch_bus1,
  output logic [65:0] prefetch_to_fetch_bus2,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_addr_ok,
  input  logic        bpu_pred_taken,
  input  logic        bpu_pred_slot,
  input  logic [31:0] bpu_pred_target
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        adel;

  assign icache_req   = (state == RUN) && fs_allowin && !flush && !br_redirect;
  assign icache_addr  = {pc[31:2], 2'b00};
  assign pfs_to_valid = icache_req && icache_addr_ok;
  assign adel         = (pc[1:0] != 2'b00);

  // Both slots carry the same exception: the whole pair is fetched from pc.
  assign prefetch_to_fetch_bus1 = pfs_to_valid ? {1'b1, pc, adel, pc} : '0;
  assign prefetch_to_fetch_bus2 = pfs_to_valid ? {1'b1, pc + 32'd4, adel, pc} : '0;

`ifdef PFS_BPU_EN
  // A taken branch in slot 1 has its delay slot in the next pair, so the
  // target is parked until that pair has been accepted.
  logic        pend_valid;
  logic [31:0] pend_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      if (state == BOOT) state <= RUN;
      if (flush) begin
        pc         <= flush_pc;
        state      <= RUN;
        pend_valid <= 1'b0;
      end else if (br_redirect) begin
        pc         <= br_target;
        state      <= RUN;
        pend_valid <= 1'b0;
      end else if (pfs_to_valid && adel) begin
        state <= HALT;
      end else if (pfs_to_valid) begin
        if (pend_valid) begin
          pc         <= pend_target;
          pend_valid <= 1'b0;
        end else if (bpu_pred_taken && !bpu_pred_slot) begin
          pc <= bpu_pred_target;
        end else if (bpu_pred_taken) begin
          pc          <= pc + PC_STEP;
          pend_valid  <= 1'b1;
          pend_target <= bpu_pred_target;
        end else begin
          pc <= pc + PC_STEP;
        end
      end
    end
  end
`else
  logic unused_bpu;
  assign unused_bpu = ^{bpu_pred_taken, bpu_pred_slot, bpu_pred_target};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      if (state == BOOT) state <= RUN;
      if (flush) begin
        pc    <= flush_pc;
        state <= RUN;
      end else if (br_redirect) begin
        pc    <= br_target;
        state <= RUN;
      end else if (pfs_to_valid && adel) begin
        state <= HALT;
      end else if (pfs_to_valid) begin
        pc <= pc + PC_STEP;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_stage.sv
module tb_prefetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        fs_allowin;
  logic        pfs_to_valid;
  logic [65:0] bus1, bus2;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        bpu_pred_taken;
  logic        bpu_pred_slot;
  logic [31:0] bpu_pred_target;

  int pass_cnt = 0;
  int total    = 0;

  prefetch_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .br_redirect(br_redirect), .br_target(br_target), .fs_allowin(fs_allowin),
    .pfs_to_valid(pfs_to_valid), .prefetch_to_fetch_bus1(bus1),
    .prefetch_to_fetch_bus2(bus2), .icache_req(icache_req),
    .icache_addr(icache_addr), .icache_addr_ok(icache_addr_ok),
    .bpu_pred_taken(bpu_pred_taken), .bpu_pred_slot(bpu_pred_slot),
    .bpu_pred_target(bpu_pred_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [65:0] mk_bus(input logic v, input logic [31:0] p,
                                         input logic a, input logic [31:0] b);
    return {v, p, a, b};
  endfunction

  typedef struct {
    logic        allow, ok, fl;
    logic [31:0] fpc;
    logic        br;
    logic [31:0] btgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;   // bus1 pc (bus2 is +4) when e_vld
    logic        e_adel;
  } vec_t;

  vec_t tbl[16];

  // Drive at negedge; outputs then settle well before the next posedge.
  task automatic drive(input logic al, input logic ok, input logic fl, input logic [31:0] fp,
                       input logic br, input logic [31:0] bt);
    @(negedge clk);
    fs_allowin = al; icache_addr_ok = ok; flush = fl; flush_pc = fp;
    br_redirect = br; br_target = bt;
    #1;
  endtask

  task automatic chk_pair(input string tag, input logic [31:0] p, input logic a);
    chk({tag, ".bus1"}, bus1, mk_bus(1'b1, p, a, p));
    chk({tag, ".bus2"}, bus2, mk_bus(1'b1, p + 32'd4, a, p));
  endtask

  function automatic vec_t v(input logic al, input logic ok, input logic fl, input logic [31:0] fp,
                             input logic br, input logic [31:0] bt, input logic er,
                             input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                             input logic ead);
    vec_t r;
    r.allow = al; r.ok = ok; r.fl = fl; r.fpc = fp; r.br = br; r.btgt = bt;
    r.e_req = er; r.e_addr = ea; r.e_vld = ev; r.e_pc = ep; r.e_adel = ead;
    return r;
  endfunction

  // Reference model state: the PC to be fetched and whether the stage is halted.
  logic [31:0] m_pc;
  logic        m_halt;

  initial begin
    reset = 1'b1; flush = 0; flush_pc = 0; br_redirect = 0; br_target = 0;
    fs_allowin = 0; icache_addr_ok = 0;
    bpu_pred_taken = 0; bpu_pred_slot = 0; bpu_pred_target = 0;

    tbl[0]  = v(1,1,0,0,0,0,                   0,32'hBFC00000,0,0,0); // BOOT idle
    tbl[1]  = v(1,1,0,0,0,0,                   1,32'hBFC00000,1,32'hBFC00000,0);
    tbl[2]  = v(1,1,0,0,0,0,                   1,32'hBFC00008,1,32'hBFC00008,0);
    tbl[3]  = v(1,0,0,0,0,0,                   1,32'hBFC00010,0,0,0);
    tbl[4]  = v(1,0,0,0,0,0,                   1,32'hBFC00010,0,0,0);
    tbl[5]  = v(1,0,0,0,0,0,                   1,32'hBFC00010,0,0,0);
    tbl[6]  = v(1,1,0,0,0,0,                   1,32'hBFC00010,1,32'hBFC00010,0);
    tbl[7]  = v(1,1,1,32'hBFC00380,1,32'h80001000, 0,32'hBFC00018,0,0,0);
    tbl[8]  = v(0,1,0,0,0,0,                   0,32'hBFC00380,0,0,0);
    tbl[9]  = v(1,1,0,0,0,0,                   1,32'hBFC00380,1,32'hBFC00380,0);
    tbl[10] = v(1,1,0,0,1,32'h80000102,        0,32'hBFC00388,0,0,0);
    tbl[11] = v(1,1,0,0,0,0,                   1,32'h80000100,1,32'h80000102,1);
    tbl[12] = v(1,1,0,0,0,0,                   0,32'h80000100,0,0,0); // HALT
    tbl[13] = v(1,1,0,0,0,0,                   0,32'h80000100,0,0,0);
    tbl[14] = v(1,1,1,32'hBFC00380,0,0,        0,32'h80000100,0,0,0);
    tbl[15] = v(1,1,0,0,0,0,                   1,32'hBFC00380,1,32'hBFC00380,0);

    #12;
    chk("reset.req", {65'b0, icache_req}, 66'd0);
    chk("reset.vld", {65'b0, pfs_to_valid}, 66'd0);
    chk("reset.bus1", bus1, 66'd0);
    chk("reset.bus2", bus2, 66'd0);
    chk("reset.addr", {34'b0, icache_addr}, {34'b0, 32'hBFC00000});
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      string n;
      n = $sformatf("tbl%0d", i);
      if (i == 0) begin
        fs_allowin = tbl[i].allow; icache_addr_ok = tbl[i].ok; #1;
      end else
        drive(tbl[i].allow, tbl[i].ok, tbl[i].fl, tbl[i].fpc, tbl[i].br, tbl[i].btgt);
      chk({n, ".req"},  {65'b0, icache_req},   {65'b0, tbl[i].e_req});
      chk({n, ".addr"}, {34'b0, icache_addr},  {34'b0, tbl[i].e_addr});
      chk({n, ".vld"},  {65'b0, pfs_to_valid}, {65'b0, tbl[i].e_vld});
      if (tbl[i].e_vld) chk_pair(n, tbl[i].e_pc, tbl[i].e_adel);
      else begin
        chk({n, ".bus1z"}, bus1, 66'd0);
        chk({n, ".bus2z"}, bus2, 66'd0);
      end
    end

    // PC wrap-around
    drive(1,1,1,32'hFFFFFFF8,0,0);
    drive(1,1,0,0,0,0);
    chk("wrap.addr", {34'b0, icache_addr}, {34'b0, 32'hFFFFFFF8});
    chk_pair("wrap", 32'hFFFFFFF8, 1'b0);
    drive(1,1,0,0,0,0);
    chk("wrap.next", {34'b0, icache_addr}, {34'b0, 32'h00000000});
    chk("wrap.adel", {65'b0, bus1[32]}, 66'd0);

`ifdef PFS_BPU_EN
    drive(1,1,1,32'h80000000,0,0);
    drive(1,1,0,0,0,0);
    bpu_pred_taken = 1; bpu_pred_slot = 1; bpu_pred_target = 32'h80002000; #1;
    chk("bpu1.addr", {34'b0, icache_addr}, {34'b0, 32'h80000000});
    drive(1,1,0,0,0,0);
    bpu_pred_slot = 0; bpu_pred_target = 32'h12345678; #1; // ignored: pending wins
    chk("bpu1.delay", {34'b0, icache_addr}, {34'b0, 32'h80000008});
    drive(1,1,0,0,0,0);
    bpu_pred_taken = 1; bpu_pred_slot = 0; bpu_pred_target = 32'h80003000; #1;
    chk("bpu1.tgt", {34'b0, icache_addr}, {34'b0, 32'h80002000});
    drive(1,1,0,0,0,0);
    bpu_pred_taken = 0; #1;
    chk("bpu0.tgt", {34'b0, icache_addr}, {34'b0, 32'h80003000});
`endif

    // Randomized run against the model; predictor left idle.
    bpu_pred_taken = 0;
    drive(0,0,1,32'h00400000,0,0);
    m_pc = 32'h00400000; m_halt = 0;
    for (int c = 0; c < 400; c++) begin
      logic al, ok, fl, br, er, ev, ad;
      logic [31:0] fp, bt;
      al = ($urandom_range(0,3) != 0);
      ok = ($urandom_range(0,2) != 0);
      fl = ($urandom_range(0,15) == 0);
      br = ($urandom_range(0,11) == 0);
      fp = {$urandom_range(0,255), 8'h00, $urandom_range(0,255), 6'b0,
            ($urandom_range(0,5) == 0) ? 2'($urandom_range(1,3)) : 2'b00};
      bt = {$urandom, 2'b00} ^ {30'b0, ($urandom_range(0,5) == 0) ? 2'b10 : 2'b00};
      if ($urandom_range(0,40) == 0) bt = 32'hFFFFFFF8;
      drive(al, ok, fl, fp, br, bt);
      er = !m_halt && al && !fl && !br;
      ev = er && ok;
      ad = (m_pc % 4) != 0;
      chk($sformatf("rnd%0d.req", c),  {65'b0, icache_req},   {65'b0, er});
      chk($sformatf("rnd%0d.addr", c), {34'b0, icache_addr},  {34'b0, m_pc - (m_pc % 4)});
      chk($sformatf("rnd%0d.b1", c), bus1, ev ? mk_bus(1, m_pc, ad, m_pc) : 66'd0);
      chk($sformatf("rnd%0d.b2", c), bus2, ev ? mk_bus(1, m_pc + 4, ad, m_pc) : 66'd0);
      if (fl) begin m_pc = fp; m_halt = 0; end
      else if (br) begin m_pc = bt; m_halt = 0; end
      else if (ev && ad) m_halt = 1;
      else if (ev) m_pc = m_pc + 8;
    end

    // Asynchronous reset in the middle of an active request.
    drive(1,0,1,32'h00001000,0,0);
    drive(1,0,0,0,0,0);
    chk("mid.req_before", {65'b0, icache_req}, 66'd1);
    #2 reset = 1'b1; #1;
    chk("mid.req", {65'b0, icache_req}, 66'd0);
    chk("mid.addr", {34'b0, icache_addr}, {34'b0, 32'hBFC00000});
    icache_addr_ok = 1; #1;
    chk("mid.vld", {65'b0, pfs_to_valid}, 66'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
